// File: rtl/tri_mode_ethernet_mac_tx_arb.sv
// Round-robin, frame-locked arbiter that merges N_SRC AXI-Stream byte sources onto one MAC TX stream.
// Frames longer than MAX_LEN are cut at MAX_LEN bytes and the rest of the source frame is discarded.
module tri_mode_ethernet_mac_tx_arb #(
    parameter int N_SRC   = 4,
    parameter int MAX_LEN = 1514
) (
    input  logic                 tx_mac_aclk,
    input  logic                 tx_mac_reset,
    input  logic [N_SRC-1:0]     src_enable,
    input  logic [8*N_SRC-1:0]   s_axis_tdata,
    input  logic [N_SRC-1:0]     s_axis_tvalid,
    input  logic [N_SRC-1:0]     s_axis_tlast,
    output logic [N_SRC-1:0]     s_axis_tready,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    input  logic                 m_axis_tready,
    output logic [N_SRC-1:0]     grant,
    output logic                 frame_done,
    output logic                 err_oversize
);

    localparam int          PTR_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [11:0] LAST_CNT = 12'(MAX_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   gidx_q, gidx_d;
    logic [11:0]        beat_cnt_q, beat_cnt_d;

    logic [7:0]         lane_data [N_SRC];
    logic [PTR_W-1:0]   rot_idx [N_SRC];
    logic [N_SRC-1:0]   req;
    logic [N_SRC-1:0]   req_rot;
    logic               pick_valid;
    logic [PTR_W-1:0]   pick_idx;
    logic               g_valid;
    logic               g_last;
    logic               at_limit;
    logic [PTR_W-1:0]   next_ptr;

    assign req     = s_axis_tvalid & src_enable;
    // Rotate requests so bit j corresponds to source (rr_ptr + j) mod N_SRC.
    assign req_rot = N_SRC'({req, req} >> rr_ptr_q);

    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_lane
            logic [PTR_W:0] sum;
            assign lane_data[gi] = s_axis_tdata[8*gi +: 8];
            assign sum           = {1'b0, rr_ptr_q} + (PTR_W+1)'(gi);
            assign rot_idx[gi]   = (sum >= (PTR_W+1)'(N_SRC)) ? PTR_W'(sum - (PTR_W+1)'(N_SRC))
                                                              : PTR_W'(sum);
            assign grant[gi]     = (state_q != IDLE) && (gidx_q == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int j = N_SRC - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                pick_valid = 1'b1;
                pick_idx   = rot_idx[j];
            end
        end
    end

    assign g_valid  = s_axis_tvalid[gidx_q];
    assign g_last   = s_axis_tlast[gidx_q];
    assign at_limit = (beat_cnt_q == LAST_CNT);
    assign next_ptr = (gidx_q == PTR_W'(N_SRC - 1)) ? '0 : gidx_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        gidx_d        = gidx_q;
        beat_cnt_d    = beat_cnt_q;
        s_axis_tready = '0;
        m_axis_tdata  = 8'h00;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        frame_done    = 1'b0;
        err_oversize  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d    = XFER;
                    gidx_d     = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            XFER: begin
                m_axis_tdata  = lane_data[gidx_q];
                m_axis_tvalid = g_valid;
                m_axis_tlast  = g_last || at_limit;
                s_axis_tready = grant & {N_SRC{m_axis_tready}};
                if (g_valid && m_axis_tready) begin
                    beat_cnt_d = beat_cnt_q + 12'd1;
                    if (g_last) begin
                        frame_done = 1'b1;
                        rr_ptr_d   = next_ptr;
                        state_d    = IDLE;
                    end else if (at_limit) begin
                        frame_done   = 1'b1;
                        err_oversize = 1'b1;
                        state_d      = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Swallow the tail of a truncated frame without presenting it to the MAC.
                s_axis_tready = grant;
                if (g_valid && g_last) begin
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge tx_mac_aclk or posedge tx_mac_reset) begin
        if (tx_mac_reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            gidx_q     <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gidx_q     <= gidx_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule
